mem_stage_param: RTL and testbench

Parametrised pipelined-CPU memory stage: internal data memory with configurable access latency, byte/halfword/word load-store with lane steering and sign/zero extension, and misalignment detection. It drives a stall handshake to the upstream stages and registers results into the MEM/WB pipeline register.
Sits between the EX/MEM register and writeback. With MEM_LATENCY=1 its timing matches the single-cycle memory stage.

---
 rtl/mem_stage_param_if.sv | 38 +++
 rtl/mem_stage_param.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_stage_param.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_param_if.sv
// Signal bundle between the EX/MEM register, the memory stage and the MEM/WB register.
// The master side drives the instruction slot; the slave side (the stage) answers with stall and writeback.
interface mem_stage_param_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              mem_read;
  logic              mem_write;
  logic              mem_to_reg;
  logic [1:0]        size;
  logic              load_unsigned;
  logic              reg_write;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  rt_in;
  logic [REG_W-1:0]  rd_in;
  logic              flush;
  logic              stall;
  logic              wb_valid;
  logic              wb_reg_write;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_rt;
  logic [REG_W-1:0]  wb_rd;
  logic              misaligned;

  modport master (
    output in_valid, mem_read, mem_write, mem_to_reg, size, load_unsigned,
           reg_write, alu_result, store_data, rt_in, rd_in, flush,
    input  stall, wb_valid, wb_reg_write, wb_data, wb_rt, wb_rd, misaligned
  );

  modport slave (
    input  in_valid, mem_read, mem_write, mem_to_reg, size, load_unsigned,
           reg_write, alu_result, store_data, rt_in, rd_in, flush,
    output stall, wb_valid, wb_reg_write, wb_data, wb_rt, wb_rd, misaligned
  );
endinterface

// File: rtl/mem_stage_param.sv
// Pipelined-CPU memory stage: byte-enabled data memory with a configurable access latency,
// lane steering with sign/zero extension, misalignment detection and the MEM/WB register.
module mem_stage_param #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 1,
  parameter int REG_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  mem_stage_param_if.slave bus
);

  localparam int NB      = DATA_W / 8;
  localparam int LANE_W  = $clog2(NB);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(MEM_LATENCY) + 1;
  localparam int SIGN_HI = (DATA_W >= 64) ? 63 : 31;
  localparam bit MULTI   = (MEM_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wb_valid_q;
  logic              wb_reg_write_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [REG_W-1:0]  wb_rt_q;
  logic [REG_W-1:0]  wb_rd_q;
  logic              mis_q;

  logic              memop_s;
  logic              mis_s;
  logic              mis_op_s;
  logic              go_s;
  logic              stall_s;
  logic              done_s;
  logic              we_s;
  logic [IDX_W-1:0]  idx_s;
  logic [LANE_W-1:0] lane_s;
  logic [3:0]        nbytes_s;
  logic              sign_s;
  logic [NB-1:0]     be_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] rdata_s;
  logic [DATA_W-1:0] load_s;

  // Upper address bits are dropped, so the word index wraps around the array.
  assign idx_s    = bus.alu_result[LANE_W +: IDX_W];
  assign lane_s   = bus.alu_result[LANE_W-1:0];
  assign memop_s  = bus.in_valid & (bus.mem_read | bus.mem_write);
  assign mis_op_s = memop_s & mis_s;
  assign go_s     = memop_s & ~mis_s;
  assign we_s     = done_s & bus.in_valid & bus.mem_write & ~mis_s;

  always_comb begin
    mis_s = 1'b0;
    case (bus.size)
      2'd0:    mis_s = 1'b0;
      2'd1:    mis_s = bus.alu_result[0];
      2'd2:    mis_s = |bus.alu_result[1:0];
      2'd3:    mis_s = (DATA_W < 64) ? 1'b1 : (|bus.alu_result[2:0]);
      default: mis_s = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (go_s && MULTI) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end
        end
        BUSY: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            state_d = BUSY;
            cnt_d   = cnt_q - CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // done_s marks the edge on which the slot leaves the stage; reset and flush kill it.
  always_comb begin
    stall_s = 1'b0;
    done_s  = 1'b0;
    if (bus.flush || !reset) begin
      stall_s = 1'b0;
      done_s  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go_s && MULTI) begin
            stall_s = 1'b1;
            done_s  = 1'b0;
          end else begin
            stall_s = 1'b0;
            done_s  = 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q != {CNT_W{1'b0}}) begin
            stall_s = 1'b1;
            done_s  = 1'b0;
          end else begin
            stall_s = 1'b0;
            done_s  = 1'b1;
          end
        end
        default: begin
          stall_s = 1'b0;
          done_s  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata_s  = mem_q[idx_s] >> (8 * int'(lane_s));
    nbytes_s = 4'd4;
    sign_s   = 1'b0;
    case (bus.size)
      2'd0: begin
        nbytes_s = 4'd1;
        sign_s   = rdata_s[7];
      end
      2'd1: begin
        nbytes_s = 4'd2;
        sign_s   = rdata_s[15];
      end
      2'd2: begin
        nbytes_s = 4'd4;
        sign_s   = rdata_s[31];
      end
      2'd3: begin
        nbytes_s = (DATA_W >= 64) ? 4'd8 : 4'd4;
        sign_s   = rdata_s[SIGN_HI];
      end
      default: begin
        nbytes_s = 4'd4;
        sign_s   = 1'b0;
      end
    endcase
    load_s = rdata_s;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= 8 * int'(nbytes_s)) begin
        load_s[i] = sign_s & ~bus.load_unsigned;
      end else begin
        load_s[i] = rdata_s[i];
      end
    end
  end

  always_comb begin
    wdata_s = bus.store_data << (8 * int'(lane_s));
    be_s    = {NB{1'b0}};
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(lane_s)) && (b < int'(lane_s) + int'(nbytes_s))) begin
        be_s[b] = 1'b1;
      end else begin
        be_s[b] = 1'b0;
      end
    end
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int b = 0; b < NB; b++) begin
        if (be_s[b]) begin
          mem_q[idx_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= {DATA_W{1'b0}};
      wb_rt_q        <= {REG_W{1'b0}};
      wb_rd_q        <= {REG_W{1'b0}};
      mis_q          <= 1'b0;
    end else if (bus.flush) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      mis_q          <= 1'b0;
    end else if (done_s) begin
      wb_valid_q     <= bus.in_valid;
      wb_reg_write_q <= bus.in_valid & bus.reg_write & ~mis_op_s;
      mis_q          <= mis_op_s;
      wb_rt_q        <= bus.rt_in;
      wb_rd_q        <= bus.rd_in;
      wb_data_q      <= (bus.mem_to_reg && !mis_op_s) ? load_s : bus.alu_result;
    end else begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      mis_q          <= 1'b0;
    end
  end

  assign bus.stall        = stall_s;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_reg_write = wb_reg_write_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_rt        = wb_rt_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.misaligned   = mis_q;

endmodule

// File: tb/tb_mem_stage_param.sv
// Scoreboard bench: three stage instances (32b/lat1, 32b/lat3, 64b/lat4) share one stimulus bus,
// selected per operation; expected writebacks are queued at issue and matched when wb_valid rises.
module tb_mem_stage_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] data;
    logic        rw;
    logic        mis;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q0[$];
  exp_t sb_q1[$];
  exp_t sb_q2[$];

  int          t_sel;
  logic        t_valid, t_rd, t_wr, t_m2r, t_uns, t_rw, t_flush;
  logic [1:0]  t_size;
  logic [63:0] t_addr, t_sdata;
  logic [4:0]  t_rt, t_rdr;

  mem_stage_param_if #(.DATA_W(32), .REG_W(5)) ifa ();
  mem_stage_param_if #(.DATA_W(32), .REG_W(5)) ifb ();
  mem_stage_param_if #(.DATA_W(64), .REG_W(5)) ifc ();

  mem_stage_param #(.DATA_W(32), .DEPTH(256), .MEM_LATENCY(1), .REG_W(5)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  mem_stage_param #(.DATA_W(32), .DEPTH(256), .MEM_LATENCY(3), .REG_W(5)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));
  mem_stage_param #(.DATA_W(64), .DEPTH(256), .MEM_LATENCY(4), .REG_W(5)) dut_c (
    .clk(clk), .reset(reset), .bus(ifc));

  assign ifa.in_valid      = t_valid && (t_sel == 0);
  assign ifa.flush         = t_flush && (t_sel == 0);
  assign ifa.mem_read      = t_rd;
  assign ifa.mem_write     = t_wr;
  assign ifa.mem_to_reg    = t_m2r;
  assign ifa.size          = t_size;
  assign ifa.load_unsigned = t_uns;
  assign ifa.reg_write     = t_rw;
  assign ifa.alu_result    = t_addr[31:0];
  assign ifa.store_data    = t_sdata[31:0];
  assign ifa.rt_in         = t_rt;
  assign ifa.rd_in         = t_rdr;

  assign ifb.in_valid      = t_valid && (t_sel == 1);
  assign ifb.flush         = t_flush && (t_sel == 1);
  assign ifb.mem_read      = t_rd;
  assign ifb.mem_write     = t_wr;
  assign ifb.mem_to_reg    = t_m2r;
  assign ifb.size          = t_size;
  assign ifb.load_unsigned = t_uns;
  assign ifb.reg_write     = t_rw;
  assign ifb.alu_result    = t_addr[31:0];
  assign ifb.store_data    = t_sdata[31:0];
  assign ifb.rt_in         = t_rt;
  assign ifb.rd_in         = t_rdr;

  assign ifc.in_valid      = t_valid && (t_sel == 2);
  assign ifc.flush         = t_flush && (t_sel == 2);
  assign ifc.mem_read      = t_rd;
  assign ifc.mem_write     = t_wr;
  assign ifc.mem_to_reg    = t_m2r;
  assign ifc.size          = t_size;
  assign ifc.load_unsigned = t_uns;
  assign ifc.reg_write     = t_rw;
  assign ifc.alu_result    = t_addr;
  assign ifc.store_data    = t_sdata;
  assign ifc.rt_in         = t_rt;
  assign ifc.rd_in         = t_rdr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic stall_of(input int k);
    case (k)
      0:       return ifa.stall;
      1:       return ifb.stall;
      default: return ifc.stall;
    endcase
  endfunction

  function automatic logic wbv_of(input int k);
    case (k)
      0:       return ifa.wb_valid;
      1:       return ifb.wb_valid;
      default: return ifc.wb_valid;
    endcase
  endfunction

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0:       sb_q0.push_back(e);
      1:       sb_q1.push_back(e);
      default: sb_q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int k, input logic v, input logic rw, input logic mis,
                     input logic [63:0] d, input logic [4:0] rtv, input logic [4:0] rdv);
    exp_t e;
    int   sz;
    if (v) begin
      sz = (k == 0) ? sb_q0.size() : ((k == 1) ? sb_q1.size() : sb_q2.size());
      if (sz == 0) begin
        check_eq($sformatf("unexpected_wb_dut%0d", k), 64'(v), 64'd0);
      end else begin
        case (k)
          0:       e = sb_q0.pop_front();
          1:       e = sb_q1.pop_front();
          default: e = sb_q2.pop_front();
        endcase
        if (!e.mis) check_eq($sformatf("wb_data_dut%0d", k), d, e.data);
        check_eq($sformatf("wb_reg_write_dut%0d", k), 64'(rw), 64'(e.rw));
        check_eq($sformatf("misaligned_dut%0d", k), 64'(mis), 64'(e.mis));
        check_eq($sformatf("wb_rt_rd_dut%0d", k), 64'({rtv, rdv}), 64'({e.rt, e.rd}));
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon(0, ifa.wb_valid, ifa.wb_reg_write, ifa.misaligned, 64'(ifa.wb_data), ifa.wb_rt, ifa.wb_rd);
      mon(1, ifb.wb_valid, ifb.wb_reg_write, ifb.misaligned, 64'(ifb.wb_data), ifb.wb_rt, ifb.wb_rd);
      mon(2, ifc.wb_valid, ifc.wb_reg_write, ifc.misaligned, ifc.wb_data, ifc.wb_rt, ifc.wb_rd);
    end
  end

  task automatic rst_chk(input string tag);
    check_eq({tag, "_a_flags"}, 64'({ifa.wb_valid, ifa.wb_reg_write, ifa.misaligned, ifa.stall, ifa.wb_rt, ifa.wb_rd}), 64'd0);
    check_eq({tag, "_a_data"}, 64'(ifa.wb_data), 64'd0);
    check_eq({tag, "_b_flags"}, 64'({ifb.wb_valid, ifb.wb_reg_write, ifb.misaligned, ifb.stall, ifb.wb_rt, ifb.wb_rd}), 64'd0);
    check_eq({tag, "_b_data"}, 64'(ifb.wb_data), 64'd0);
    check_eq({tag, "_c_flags"}, 64'({ifc.wb_valid, ifc.wb_reg_write, ifc.misaligned, ifc.stall, ifc.wb_rt, ifc.wb_rd}), 64'd0);
    check_eq({tag, "_c_data"}, ifc.wb_data, 64'd0);
  endtask

  // Issues one op on dut k, holds it while stall is high, then checks the stall length.
  task automatic do_op(input int k, input logic r, input logic w, input logic [1:0] sz,
                       input logic uns, input logic [63:0] a, input logic [63:0] sd,
                       input logic [63:0] exp_d, input logic exp_mis, input int exp_stall);
    exp_t e;
    int   n;
    logic st;
    t_sel   = k;
    t_valid = 1'b1;
    t_rd    = r;
    t_wr    = w;
    t_size  = sz;
    t_uns   = uns;
    t_m2r   = r & ~w;
    t_rw    = r | ~w;
    t_addr  = a;
    t_sdata = sd;
    t_rdr   = t_rdr + 5'd1;
    t_rt    = ~t_rdr;
    e.data  = exp_d;
    e.rw    = t_rw & ~exp_mis;
    e.mis   = exp_mis;
    e.rt    = t_rt;
    e.rd    = t_rdr;
    sb_push(k, e);
    n = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (n > 0) check_eq($sformatf("bubble_wb_valid_dut%0d", k), 64'(wbv_of(k)), 64'd0);
      st = stall_of(k);
      @(posedge clk);
      #1;
      if (!st) break;
      n++;
    end
    check_eq($sformatf("stall_cycles_dut%0d_a%0h", k, a), 64'(n), 64'(exp_stall));
    t_valid = 1'b0;
    t_rd    = 1'b0;
    t_wr    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    t_sel   = 1;
    t_valid = 1'b1;
    t_rd    = 1'b1;
    t_wr    = 1'b0;
    t_m2r   = 1'b1;
    t_uns   = 1'b0;
    t_rw    = 1'b1;
    t_flush = 1'b0;
    t_size  = 2'd2;
    t_addr  = 64'h40;
    t_sdata = 64'd0;
    t_rt    = 5'd0;
    t_rdr   = 5'd0;
    repeat (2) @(negedge clk);
    rst_chk("reset");
    t_valid = 1'b0;
    t_rd    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // 32-bit, single-cycle memory
    do_op(0, 1'b0, 1'b1, 2'd2, 1'b0, 64'h10, 64'hDEADBEEF, 64'h10, 1'b0, 0);
    do_op(0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h10, 64'h0, 64'hDEADBEEF, 1'b0, 0);
    do_op(0, 1'b0, 1'b1, 2'd2, 1'b0, 64'h10, 64'h11223344, 64'h10, 1'b0, 0);
    do_op(0, 1'b0, 1'b1, 2'd0, 1'b0, 64'h13, 64'h12345680, 64'h13, 1'b0, 0);
    do_op(0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h10, 64'h0, 64'h80223344, 1'b0, 0);
    do_op(0, 1'b1, 1'b0, 2'd0, 1'b0, 64'h13, 64'h0, 64'hFFFFFF80, 1'b0, 0);
    do_op(0, 1'b1, 1'b0, 2'd0, 1'b1, 64'h13, 64'h0, 64'h00000080, 1'b0, 0);
    do_op(0, 1'b1, 1'b0, 2'd1, 1'b0, 64'h12, 64'h0, 64'hFFFF8022, 1'b0, 0);
    do_op(0, 1'b1, 1'b0, 2'd1, 1'b1, 64'h12, 64'h0, 64'h00008022, 1'b0, 0);
    do_op(0, 1'b0, 1'b1, 2'd2, 1'b0, 64'h20, 64'hCAFEF00D, 64'h20, 1'b0, 0);
    do_op(0, 1'b1, 1'b0, 2'd1, 1'b0, 64'h21, 64'h0, 64'h0, 1'b1, 0);
    do_op(0, 1'b0, 1'b1, 2'd1, 1'b0, 64'h21, 64'hBEEF, 64'h0, 1'b1, 0);
    do_op(0, 1'b0, 1'b1, 2'd2, 1'b0, 64'h22, 64'h99999999, 64'h0, 1'b1, 0);
    do_op(0, 1'b1, 1'b0, 2'd3, 1'b0, 64'h20, 64'h0, 64'h0, 1'b1, 0);
    do_op(0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h20, 64'h0, 64'hCAFEF00D, 1'b0, 0);
    do_op(0, 1'b0, 1'b0, 2'd2, 1'b0, 64'h1234, 64'h0, 64'h1234, 1'b0, 0);
    do_op(0, 1'b0, 1'b1, 2'd2, 1'b0, 64'h410, 64'h55AA55AA, 64'h410, 1'b0, 0);
    do_op(0, 1'b1, 1'b0, 2'd2, 1'b0, 64'h10, 64'h0, 64'h55AA55AA, 1'b0, 0);

    // 32-bit, three-cycle memory
    do_op(1, 1'b0, 1'b1, 2'd2, 1'b0, 64'h40, 64'hA5A5A5A5, 64'h40, 1'b0, 2);
    do_op(1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h40, 64'h0, 64'hA5A5A5A5, 1'b0, 2);
    do_op(1, 1'b0, 1'b0, 2'd2, 1'b0, 64'h77, 64'h0, 64'h77, 1'b0, 0);
    do_op(1, 1'b1, 1'b0, 2'd1, 1'b0, 64'h41, 64'h0, 64'h0, 1'b1, 0);
    do_op(1, 1'b1, 1'b0, 2'd1, 1'b1, 64'h42, 64'h0, 64'h0000A5A5, 1'b0, 2);

    // 64-bit, four-cycle memory
    do_op(2, 1'b0, 1'b1, 2'd3, 1'b0, 64'h8, 64'h0123456789ABCDEF, 64'h8, 1'b0, 3);
    do_op(2, 1'b1, 1'b0, 2'd2, 1'b1, 64'hC, 64'h0, 64'h0000000001234567, 1'b0, 3);
    do_op(2, 1'b1, 1'b0, 2'd2, 1'b0, 64'h8, 64'h0, 64'hFFFFFFFF89ABCDEF, 1'b0, 3);
    do_op(2, 1'b1, 1'b0, 2'd3, 1'b0, 64'h8, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3);
    do_op(2, 1'b1, 1'b0, 2'd3, 1'b0, 64'hC, 64'h0, 64'h0, 1'b1, 0);

    // Store killed by flush in its second cycle
    t_sel   = 2;
    t_valid = 1'b1;
    t_wr    = 1'b1;
    t_m2r   = 1'b0;
    t_rw    = 1'b0;
    t_size  = 2'd3;
    t_addr  = 64'h8;
    t_sdata = 64'h1111111111111111;
    @(negedge clk);
    check_eq("flush_pre_stall", 64'(ifc.stall), 64'd1);
    @(posedge clk);
    #1;
    t_flush = 1'b1;
    @(negedge clk);
    check_eq("flush_stall", 64'(ifc.stall), 64'd0);
    @(posedge clk);
    #1;
    t_flush = 1'b0;
    t_valid = 1'b0;
    t_wr    = 1'b0;
    @(negedge clk);
    check_eq("flush_wb_valid", 64'({ifc.wb_valid, ifc.wb_reg_write, ifc.misaligned}), 64'd0);
    @(posedge clk);
    #1;
    do_op(2, 1'b1, 1'b0, 2'd3, 1'b0, 64'h8, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3);

    // Reset while the store is BUSY
    t_sel   = 2;
    t_valid = 1'b1;
    t_wr    = 1'b1;
    t_m2r   = 1'b0;
    t_rw    = 1'b0;
    t_size  = 2'd3;
    t_addr  = 64'h8;
    t_sdata = 64'h2222222222222222;
    @(negedge clk);
    check_eq("busy_pre_stall", 64'(ifc.stall), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("busy_stall", 64'(ifc.stall), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    rst_chk("midbusy_reset");
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    t_wr    = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    do_op(2, 1'b1, 1'b0, 2'd3, 1'b0, 64'h8, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3);

    repeat (3) @(posedge clk);
    #1;
    check_eq("scoreboard_drain", 64'(sb_q0.size() + sb_q1.size() + sb_q2.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
